// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//   Central stall/flush controller for the 5-stage MIPS pipeline. It detects
//   load-use and HI/LO occupancy hazards, handles taken-branch redirects and
//   instruction-fetch wait states, and counts stalled cycles.
//
// Ports
//   clk, rstn          : clock (rising edge), async active-low reset
//   id_rs/id_rt        : source register fields of the instruction in ID
//   id_uses_rs/_rt     : ID instruction actually reads rs / rt
//   id_is_mdu          : ID holds mult/multu/div/divu
//   id_reads_hilo      : ID holds mfhi/mflo/mthi/mtlo
//   ex_mem_read, ex_rt : EX holds a load targeting ex_rt
//   ex_branch_taken    : branch/jump resolved taken in EX
//   imem_ready         : instruction memory data valid this cycle
//   pc_stall           : hold PC
//   if_id_stall        : hold IF/ID (load_stop_request)
//   if_id_flush        : load NOP into IF/ID
//   id_ex_bubble       : load NOP into ID/EX
//   mdu_busy           : HI/LO result still pending
//   stall_cycles       : saturating count of cycles with pc_stall=1
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int MDU_LATENCY = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_is_mdu,
    input  logic             id_reads_hilo,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             ex_branch_taken,
    input  logic             imem_ready,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             mdu_busy,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam logic [3:0] MDU_LAT = 4'(MDU_LATENCY);

    logic [3:0]       mdu_cnt_q, mdu_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic load_use, mdu_hz, stall;

    // $0 is never a real dependency: writes to it are discarded.
    assign load_use = ex_mem_read && (ex_rt != 5'd0) &&
                      ((id_uses_rs && (id_rs == ex_rt)) ||
                       (id_uses_rt && (id_rt == ex_rt)));
    assign mdu_hz   = (id_is_mdu || id_reads_hilo) && (mdu_cnt_q != 4'd0);
    assign stall    = load_use || mdu_hz;

    // Priority: redirect > ID hazard > fetch wait. The ID instruction is on
    // the wrong path during a redirect, so its hazards are irrelevant.
    // Everything is gated by rstn so outputs drop the instant reset asserts.
    always_comb begin
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        if (rstn) begin
            if (ex_branch_taken) begin
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
            end else if (stall) begin
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_bubble = 1'b1;
            end else if (!imem_ready) begin
                pc_stall     = 1'b1;
                if_id_flush  = 1'b1;
            end
        end
    end

    assign mdu_busy     = (mdu_cnt_q != 4'd0);
    assign stall_cycles = stall_cnt_q;

    // A taken branch does not cancel an op already past ID; the count runs on.
    always_comb begin
        mdu_cnt_d = mdu_cnt_q;
        if (id_is_mdu && !stall && !ex_branch_taken)
            mdu_cnt_d = MDU_LAT;
        else if (mdu_cnt_q != 4'd0)
            mdu_cnt_d = mdu_cnt_q - 4'd1;
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (pc_stall && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mdu_cnt_q   <= 4'd0;
            stall_cnt_q <= '0;
        end else begin
            mdu_cnt_q   <= mdu_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage MIPS pipeline. It detects load-use hazards, multiply/divide (HI/LO) occupancy hazards, taken-branch redirects and instruction-fetch wait states. It drives PC hold, the IF/ID hold input (load_stop_request), the IF/ID flush and the ID/EX bubble. It also keeps a saturating stall-cycle performance counter.

Parameters:
MDU_LATENCY, 4, cycles a mult/div occupies HI/LO after leaving ID (1..15)
CNT_W, 16, width of stall-cycle performance counter

Ports:
clk  in  1  pipeline clock, rising edge
rstn  in  1  reset, asynchronous, active-low
id_rs  in  5  rs field of instruction in ID
id_rt  in  5  rt field of instruction in ID
id_uses_rs  in  1  ID instruction reads rs
id_uses_rt  in  1  ID instruction reads rt
id_is_mdu  in  1  ID instruction is mult/multu/div/divu
id_reads_hilo  in  1  ID instruction is mfhi/mflo/mthi/mtlo
ex_mem_read  in  1  EX instruction is a load
ex_rt  in  5  destination register of EX load
ex_branch_taken  in  1  branch/jump resolved taken in EX this cycle
imem_ready  in  1  instruction memory data valid this cycle
pc_stall  out  1  hold PC
if_id_stall  out  1  hold IF/ID (drives load_stop_request)
if_id_flush  out  1  load NOP (0) into IF/ID
id_ex_bubble  out  1  load NOP into ID/EX
mdu_busy  out  1  HI/LO result pending
stall_cycles  out  CNT_W  cycles with pc_stall=1, saturating

Behaviour:
- State: mdu_cnt (4 bits), stall_cycles (CNT_W bits). Both reset to 0 asynchronously on rstn=0.
- Control outputs are combinational from inputs and state. All are forced 0 while rstn=0.
- load_use = ex_mem_read & ex_rt!=0 & ((id_uses_rs & id_rs==ex_rt) | (id_uses_rt & id_rt==ex_rt)).
- mdu_hz = (id_is_mdu | id_reads_hilo) & mdu_cnt!=0.
- stall = load_use | mdu_hz.
- mdu_busy = (mdu_cnt != 0).
- Priority 1, ex_branch_taken=1:
  - if_id_flush=1, id_ex_bubble=1, pc_stall=0, if_id_stall=0. PC loads the target.
  - ID hazards are ignored because the ID instruction is on the wrong path.
- Priority 2, stall=1:
  - pc_stall=1, if_id_stall=1, id_ex_bubble=1, if_id_flush=0.
  - Load-use stall lasts exactly 1 cycle; the load then moves to MEM.
  - mdu_hz lasts until mdu_cnt reaches 0.
- Priority 3, imem_ready=0:
  - pc_stall=1, if_id_flush=1 (NOP enters ID), if_id_stall=0, id_ex_bubble=0.
  - Repeats every cycle until imem_ready=1.
- Otherwise all control outputs are 0.
- mdu_cnt update, per rising edge:
  - If id_is_mdu & !stall & !ex_branch_taken: mdu_cnt <= MDU_LATENCY (accept).
  - Else if mdu_cnt!=0: mdu_cnt <= mdu_cnt-1.
  - A taken branch does not cancel an in-flight operation; the count continues.
  - A back-to-back mdu op stalls (mdu_hz) until mdu_cnt reaches 0, then is accepted and reloads MDU_LATENCY.
- stall_cycles increments by 1 on each edge with pc_stall=1 and sticks at all-ones (no wrap).
- if_id_stall and if_id_flush are never both 1.
- Reset mid-stall: outputs drop to 0 immediately; mdu_cnt clears. After rstn rises, the first cycle behaves as if no mdu op is pending.

Test Plan:
- Load-use: ex_mem_read=1, ex_rt=8; ID id_rs=8, id_uses_rs=1 -> pc_stall, if_id_stall and id_ex_bubble =1 for exactly 1 cycle; stall_cycles 0->1.
- Load to $0 or no true dependency: ex_rt=0, or id_rs=8 with id_uses_rs=0 -> no stall, all outputs 0.
- MDU: id_is_mdu=1 accepted at cycle 0, then mfhi in ID at cycle 1 -> stall for cycles 1..4 (mdu_cnt 4,3,2,1), released at cycle 5; mdu_busy=1 during cycles 1..4.
- Branch over hazard: ex_branch_taken=1 with load_use=1 and imem_ready=0 -> if_id_flush=1, id_ex_bubble=1, pc_stall=0, if_id_stall=0; stall_cycles unchanged.
- Fetch wait: imem_ready=0 for 3 cycles -> pc_stall=1 and if_id_flush=1 each cycle; stall_cycles=3. With load_use also active -> if_id_stall=1, if_id_flush=0.
- Async reset: assert rstn=0 mid-cycle with mdu_cnt=3 and stall active -> all outputs 0 immediately; mdu_cnt=0 and stall_cycles=0 at release. Saturation: preload stall_cycles to 0xFFFE, apply 3 stall cycles -> value 0xFFFF.
